// File: rtl/wb_burst_master_pkg.sv
// rtl/wb_burst_master_pkg.sv - shared types and constants for the Wishbone burst master
package sdrctrl_package;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    IDLE      = 2'd1,
    BURST     = 2'd2,
    FINISH    = 2'd3
  } state_t;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  localparam int DEF_AW = 26;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/wb_beat_counter.sv
// rtl/wb_beat_counter.sv - beat down-counter and byte-address incrementer for one burst
module wb_beat_counter
  import sdrctrl_package::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_bl,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam logic [AW-1:0] STRIDE = AW'(DW / 8);

  logic [7:0] remaining;

  // Address addition is AW bits wide, so it wraps at the top of the space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_bl;
    end else if (step) begin
      addr      <= addr + STRIDE;
      remaining <= remaining - 8'd1;
    end
  end

  assign last = (remaining == 8'd1);

endmodule

// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - command-driven Wishbone incrementing-burst master gated by SDRAM init
module wb_burst_master
  import sdrctrl_package::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int TO_MAX = 255
) (
  input  logic            sys_clk,
  input  logic            RESETN,
  input  logic            sdr_init_done,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  logic            cmd_we,
  input  logic [7:0]      cmd_bl,
  input  logic            wdat_valid,
  output logic            wdat_ready,
  input  logic [DW-1:0]   wdat,
  output logic            rdat_valid,
  output logic [DW-1:0]   rdat,
  output logic            wb_cyc_i,
  output logic            wb_stb_i,
  output logic            wb_we_i,
  output logic [AW-1:0]   wb_addr_i,
  output logic [DW-1:0]   wb_dat_i,
  output logic [DW/8-1:0] wb_sel_i,
  output logic [2:0]      wb_cti_i,
  input  logic            wb_ack_o,
  input  logic [DW-1:0]   wb_dat_o,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int TW = $clog2(TO_MAX + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TO_MAX - 1);

  state_t        state, state_nxt;
  logic          we_q, held, abort_q;
  logic [DW-1:0] wdat_q;
  logic [TW-1:0] to_cnt;
  logic          cmd_fire, wdat_fire, ack_ok, timeout, last;

  wb_beat_counter #(.AW(AW), .DW(DW)) u_beat_counter (
    .clk       (sys_clk),
    .rst_n     (RESETN),
    .load      (cmd_fire),
    .load_addr (cmd_addr),
    .load_bl   (cmd_bl),
    .step      (ack_ok),
    .addr      (wb_addr_i),
    .last      (last)
  );

  assign cmd_ready  = (state == IDLE) && sdr_init_done;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign wb_cyc_i   = (state == BURST);
  // Writes only strobe with a beat in hand; reads strobe for the whole burst.
  assign wb_stb_i   = wb_cyc_i && (we_q ? held : 1'b1);
  assign wb_we_i    = wb_cyc_i && we_q;
  assign wb_sel_i   = {(DW/8){wb_cyc_i}};
  assign wb_cti_i   = wb_cyc_i ? (last ? CTI_END : CTI_INCR) : 3'b000;
  assign wb_dat_i   = wdat_q;
  assign wdat_ready = wb_cyc_i && we_q && !held;
  assign wdat_fire  = wdat_valid && wdat_ready;
  assign ack_ok     = wb_stb_i && wb_ack_o;
  assign timeout    = wb_stb_i && !wb_ack_o && (to_cnt == TO_LIM);
  assign busy       = (state == BURST) || (state == FINISH);
  assign done       = (state == FINISH) && !abort_q;
  assign err        = (state == FINISH) && abort_q;

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_INIT: if (sdr_init_done) state_nxt = IDLE;
      IDLE:      if (cmd_fire) state_nxt = (cmd_bl != 8'd0) ? BURST : FINISH;
      BURST:     if ((ack_ok && last) || timeout) state_nxt = FINISH;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = WAIT_INIT;
    endcase
  end

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state      <= WAIT_INIT;
      we_q       <= 1'b0;
      held       <= 1'b0;
      abort_q    <= 1'b0;
      wdat_q     <= '0;
      to_cnt     <= '0;
      rdat_valid <= 1'b0;
      rdat       <= '0;
    end else begin
      state      <= state_nxt;
      rdat_valid <= ack_ok && !we_q;
      if (ack_ok && !we_q) rdat <= wb_dat_o;

      // A zero-length command is reported through the same abort flag as a timeout.
      if (cmd_fire) begin
        we_q    <= cmd_we;
        abort_q <= (cmd_bl == 8'd0);
      end else if (timeout) begin
        abort_q <= 1'b1;
      end

      if (cmd_fire || ack_ok || timeout) held <= 1'b0;
      else if (wdat_fire) held <= 1'b1;
      if (wdat_fire) wdat_q <= wdat;

      if (cmd_fire || ack_ok) to_cnt <= '0;
      else if (wb_stb_i) to_cnt <= to_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// tb/tb_wb_burst_master.sv - self-checking bench for wb_burst_master with a Wishbone slave model
module tb_wb_burst_master;
  localparam int AW     = 26;
  localparam int DW     = 32;
  localparam int TO_MAX = 8;

  logic            sys_clk = 1'b0;
  logic            RESETN = 1'b1;
  logic            sdr_init_done = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr = '0;
  logic            cmd_we = 1'b0;
  logic [7:0]      cmd_bl = '0;
  logic            wdat_valid = 1'b0;
  logic            wdat_ready;
  logic [DW-1:0]   wdat = '0;
  logic            rdat_valid;
  logic [DW-1:0]   rdat;
  logic            wb_cyc_i, wb_stb_i, wb_we_i;
  logic [AW-1:0]   wb_addr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic [2:0]      wb_cti_i;
  logic            wb_ack_o = 1'b0;
  logic [DW-1:0]   wb_dat_o = '0;
  logic            busy, done, err;

  wb_burst_master #(.AW(AW), .DW(DW), .TO_MAX(TO_MAX)) dut (
    .sys_clk(sys_clk), .RESETN(RESETN), .sdr_init_done(sdr_init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_we(cmd_we), .cmd_bl(cmd_bl),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
    .rdat_valid(rdat_valid), .rdat(rdat),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_cti_i(wb_cti_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
    .busy(busy), .done(done), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  int n_done, n_err, n_cyc, n_stb, n_rdy, gap_run, gap_max;
  bit ack_en = 1'b1;
  int max_wait = 0;
  int wait_cnt = 0;

  logic [AW-1:0]   q_addr[$];
  logic            q_we[$];
  logic [DW-1:0]   q_dat[$];
  logic [2:0]      q_cti[$];
  logic [DW/8-1:0] q_sel[$];
  logic [DW-1:0]   q_rdat[$];

  logic [DW-1:0] slv_mem[logic [AW-1:0]];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];

  logic [DW-1:0] wq[$];
  logic [DW-1:0] exp_wd[$];
  int  sent = 0, stall_idx = -1, stall_len = 0, stall_cnt = 0;
  bit  pend = 1'b0;

  logic [AW-1:0] cur_addr;
  bit            cur_we;
  int            cur_bl;

  function automatic logic [DW-1:0] seed_val(input logic [AW-1:0] a);
    logic [31:0] x;
    x = {6'h0, a};
    return (x * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_val(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model and bus monitor: decide ack and return data half a cycle ahead of the DUT edge.
  always @(negedge sys_clk) begin
    if (done) n_done++;
    if (err) n_err++;
    if (wb_cyc_i) n_cyc++;
    if (wb_stb_i) n_stb++;
    if (cmd_ready) n_rdy++;
    if (wb_cyc_i && !wb_stb_i) begin
      gap_run++;
      if (gap_run > gap_max) gap_max = gap_run;
    end else begin
      gap_run = 0;
    end
    if (rdat_valid) q_rdat.push_back(rdat);
    wb_ack_o = 1'b0;
    if (wb_cyc_i && wb_stb_i && ack_en) begin
      if (wait_cnt == 0) begin
        wb_ack_o = 1'b1;
        wait_cnt = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
        q_addr.push_back(wb_addr_i);
        q_we.push_back(wb_we_i);
        q_dat.push_back(wb_dat_i);
        q_cti.push_back(wb_cti_i);
        q_sel.push_back(wb_sel_i);
        if (wb_we_i) slv_mem[wb_addr_i] = wb_dat_i;
      end else begin
        wait_cnt--;
      end
    end
    wb_dat_o = slv_mem.exists(wb_addr_i) ? slv_mem[wb_addr_i] : seed_val(wb_addr_i);
  end

  // Write-data source with an optional stall before beat stall_idx.
  always @(negedge sys_clk) begin
    if (pend && wq.size() > 0) begin
      void'(wq.pop_front());
      sent++;
    end
    pend = 1'b0;
    if (wq.size() > 0 && !(sent == stall_idx && stall_cnt < stall_len)) begin
      wdat_valid = 1'b1;
      wdat = wq[0];
    end else begin
      if (wq.size() > 0) stall_cnt++;
      wdat_valid = 1'b0;
    end
    pend = wdat_valid && wdat_ready;
  end

  task automatic start_cmd(input logic [AW-1:0] a, input bit w, input int bl,
                           input bit fixed, input int s_idx, input int s_len);
    logic [DW-1:0] d;
    q_addr.delete(); q_we.delete(); q_dat.delete(); q_cti.delete(); q_sel.delete(); q_rdat.delete();
    n_done = 0; n_err = 0; n_cyc = 0; n_stb = 0; n_rdy = 0; gap_run = 0; gap_max = 0; wait_cnt = 0;
    wq.delete(); exp_wd.delete();
    sent = 0; stall_cnt = 0; stall_idx = s_idx; stall_len = s_len;
    cur_addr = a; cur_we = w; cur_bl = bl;
    if (w) begin
      for (int i = 0; i < bl; i++) begin
        d = fixed ? DW'(32'hA0 + i) : DW'($urandom);
        wq.push_back(d);
        exp_wd.push_back(d);
      end
    end
    cmd_addr = a; cmd_we = w; cmd_bl = 8'(bl); cmd_valid = 1'b1;
  endtask

  task automatic wait_accept(input string tag);
    int t = 0;
    while (!busy && t < 50) begin
      @(negedge sys_clk);
      t++;
    end
    check({tag, "_accept"}, busy, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input int exp_beats, input bit exp_done, input bit exp_err);
    int t = 0;
    logic [AW-1:0] ea;
    while ((n_done + n_err) == 0 && t < 3000) begin
      @(negedge sys_clk);
      t++;
    end
    check({tag, "_end"}, t < 3000, 1);
    repeat (3) @(negedge sys_clk);
    check({tag, "_beats"}, q_addr.size(), exp_beats);
    check({tag, "_done"}, n_done, exp_done);
    check({tag, "_err"}, n_err, exp_err);
    for (int i = 0; i < exp_beats && i < q_addr.size(); i++) begin
      ea = cur_addr + AW'(i * (DW / 8));
      check($sformatf("%s_addr%0d", tag, i), q_addr[i], ea);
      check($sformatf("%s_cti%0d", tag, i), q_cti[i], (i == cur_bl - 1) ? 3'b111 : 3'b010);
      check($sformatf("%s_we%0d", tag, i), q_we[i], cur_we);
      check($sformatf("%s_sel%0d", tag, i), q_sel[i], 4'hF);
      if (cur_we) begin
        check($sformatf("%s_wdat%0d", tag, i), q_dat[i], exp_wd[i]);
        ref_mem[ea] = exp_wd[i];
      end
    end
    if (!cur_we && exp_beats > 0) begin
      check({tag, "_rcount"}, q_rdat.size(), exp_beats);
      for (int i = 0; i < exp_beats && i < q_rdat.size(); i++) begin
        ea = cur_addr + AW'(i * (DW / 8));
        check($sformatf("%s_rdat%0d", tag, i), q_rdat[i], ref_rd(ea));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_cti_i, cmd_ready,
                          wdat_ready, rdat_valid, busy, done, err}, 0);
    check({tag, "_addr"}, wb_addr_i, 0);
    check({tag, "_wdat"}, wb_dat_i, 0);
    check({tag, "_rdat"}, rdat, 0);
  endtask

  initial begin
    logic [AW-1:0] a;
    bit w;
    int bl, si, sl, t;

    #1 RESETN = 1'b0;
    #2 check_all_zero("reset");
    @(negedge sys_clk);
    @(negedge sys_clk);
    RESETN = 1'b1;

    // Init gate: command pending while the SDRAM controller is still initialising.
    start_cmd(26'h100, 1'b1, 4, 1'b1, -1, 0);
    repeat (50) @(negedge sys_clk);
    check("gate_ready", n_rdy, 0);
    check("gate_cyc", n_cyc, 0);
    check("gate_busy", busy, 0);
    sdr_init_done = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("gate_accept", busy, 1);
    cmd_valid = 1'b0;
    finish_cmd("wr4", 4, 1'b1, 1'b0);

    start_cmd(26'h3FF_FFFC, 1'b0, 2, 1'b0, -1, 0);
    wait_accept("rdwrap");
    finish_cmd("rdwrap", 2, 1'b1, 1'b0);
    check("rdwrap_addr1_zero", q_addr.size() > 1 ? q_addr[1] : 26'h1, 0);

    start_cmd(26'h200, 1'b1, 3, 1'b0, 1, 5);
    wait_accept("wrstall");
    finish_cmd("wrstall", 3, 1'b1, 1'b0);
    check("wrstall_gap", gap_max >= 5, 1);

    start_cmd(26'h40, 1'b0, 0, 1'b0, -1, 0);
    wait_accept("bl0");
    finish_cmd("bl0", 0, 1'b0, 1'b1);
    check("bl0_nocyc", n_cyc, 0);

    ack_en = 1'b0;
    start_cmd(26'h500, 1'b0, 4, 1'b0, -1, 0);
    wait_accept("tmo");
    finish_cmd("tmo", 0, 1'b0, 1'b1);
    check("tmo_stb_cycles", n_stb, TO_MAX);
    check("tmo_rvalid", q_rdat.size(), 0);
    ack_en = 1'b1;

    for (int k = 0; k < 6; k++) begin
      a = AW'($urandom);
      a[1:0] = 2'b00;
      if (k == 0) a = 26'h3FF_FFF0;
      w = 1'($urandom);
      bl = int'($urandom_range(8, 1));
      si = (w && bl > 1) ? int'($urandom_range(bl - 1, 1)) : -1;
      sl = int'($urandom_range(3, 0));
      max_wait = int'($urandom_range(2, 0));
      start_cmd(a, w, bl, 1'b0, si, sl);
      wait_accept($sformatf("rnd%0d", k));
      finish_cmd($sformatf("rnd%0d", k), bl, 1'b1, 1'b0);
    end
    max_wait = 0;

    // Reset in the middle of an 8-beat read.
    start_cmd(26'h2000, 1'b0, 8, 1'b0, -1, 0);
    wait_accept("rst");
    t = 0;
    while (q_addr.size() < 1 && t < 100) begin
      @(negedge sys_clk);
      t++;
    end
    check("rst_beat_seen", q_addr.size() >= 1, 1);
    @(posedge sys_clk);
    #2 RESETN = 1'b0;
    sdr_init_done = 1'b0;
    #1 check_all_zero("midrst");
    check("midrst_nodone", n_done, 0);
    check("midrst_noerr", n_err, 0);
    repeat (2) @(negedge sys_clk);
    RESETN = 1'b1;
    n_cyc = 0;
    repeat (4) @(negedge sys_clk);
    check("post_rst_cyc", n_cyc, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_nodone", n_done + n_err, 0);
    sdr_init_done = 1'b1;
    start_cmd(26'h3000, 1'b1, 5, 1'b0, -1, 0);
    wait_accept("after_rst_wr");
    finish_cmd("after_rst_wr", 5, 1'b1, 1'b0);
    start_cmd(26'h3000, 1'b0, 5, 1'b0, -1, 0);
    wait_accept("after_rst_rd");
    finish_cmd("after_rst_rd", 5, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameter AW, default 26, Wishbone address width.
REQ-002 Parameter DW, default 32, Wishbone data width; wb_sel_i is DW/8 bits.
REQ-003 Parameter TO_MAX, default 255, ack-timeout limit in sys_clk cycles.
REQ-004 sys_clk  in  1  sole clock; all logic is rising-edge.
REQ-005 RESETN  in  1  reset, asynchronous and active-low.
REQ-006 sdr_init_done  in  1  SDRAM controller initialisation complete.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-008 cmd_addr  in  AW  start byte address; cmd_we  in  1  1=write; cmd_bl  in  8  burst length in beats.
REQ-009 wdat_valid / wdat_ready  in / out  1 / 1  write-data handshake; wdat  in  DW  write beat.
REQ-010 rdat_valid  out  1  read beat strobe, no backpressure; rdat  out  DW  read beat.
REQ-011 wb_cyc_i, wb_stb_i, wb_we_i  out  1  Wishbone cycle, strobe, direction.
REQ-012 wb_addr_i  out  AW; wb_dat_i  out  DW; wb_sel_i  out  DW/8; wb_cti_i  out  3.
REQ-013 wb_ack_o  in  1; wb_dat_o  in  DW  slave acknowledge and read data.
REQ-014 busy  out  1; done  out  1  one-cycle end-of-burst pulse; err  out  1  one-cycle error pulse.

Function
REQ-015 FSM states: IDLE, WAIT_INIT, BURST, FINISH; any state change is a registered transition on sys_clk.
REQ-016 IDLE: cmd_ready=1 only when sdr_init_done=1; a command is accepted when cmd_valid & cmd_ready.
REQ-017 Accepted command latches addr, we, bl; next state BURST when bl!=0, else FINISH with err pulse and no bus activity.
REQ-018 WAIT_INIT: entered from reset; leaves to IDLE on the first cycle sdr_init_done=1; sdr_init_done falling in other states is ignored.
REQ-019 BURST: wb_cyc_i=1 for the whole burst; wb_sel_i all ones; wb_we_i = latched we.
REQ-020 wb_cti_i = 3'b010 on every beat except the last, 3'b111 on the last; bl=1 gives 3'b111 on its only beat.
REQ-021 Write beat: wb_stb_i asserts only while a write beat is held; wdat_ready=1 when BURST, we=1, and no beat is held.
REQ-022 A held beat drives wb_dat_i and stays until wb_ack_o; wdat_valid low stalls with wb_stb_i=0, wb_cyc_i=1.
REQ-023 Read beat: wb_stb_i=1 continuously in BURST; each wb_ack_o yields rdat_valid=1, rdat=wb_dat_o one cycle later.
REQ-024 Each ack increments wb_addr_i by DW/8 modulo 2^AW (wrap at top, no carry out) and decrements beat count.
REQ-025 On the ack of the last beat: wb_cyc_i, wb_stb_i drop next cycle; state FINISH.
REQ-026 FINISH: done=1 for exactly one cycle (unless error path), busy=0 next cycle, return to IDLE.
REQ-027 Timeout counter counts cycles with wb_stb_i=1 and no ack; resets on ack; reaching TO_MAX aborts: cyc/stb drop, err pulses, FINISH without done.
REQ-028 busy=1 in all states except IDLE and WAIT_INIT.
REQ-029 Command input is ignored (cmd_ready=0) outside IDLE; back-to-back commands have at least one idle bus cycle between them.

Reset
REQ-030 RESETN low asynchronously forces WAIT_INIT and all outputs to 0: wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i, cmd_ready, wdat_ready, rdat_valid, rdat, busy, done, err.
REQ-031 Reset mid-burst discards the burst without done or err; no bus signal glitches high on release.
REQ-032 Deassertion takes effect at the next rising sys_clk edge.

Structure
REQ-033 The sdrctrl_package holds the FSM state enum, CTI constants (CTI_INCR=3'b010, CTI_END=3'b111) and default AW/DW.
REQ-034 One sub-module, wb_beat_counter: the beat down-counter plus the address incrementer.

Verification
REQ-035 Init gate: hold sdr_init_done=0 for 50 cycles with cmd_valid=1 -> cmd_ready=0, no wb_cyc_i; raise it -> accepted within 2 cycles.
REQ-036 Write burst addr=0x100, bl=4, data 0xA0..0xA3, ack each cycle -> addresses 0x100,0x104,0x108,0x10C; cti 010,010,010,111; one done.
REQ-037 Read burst addr=0x3FFFFFC, bl=2 -> second beat address 0x0000000; two rdat_valid carrying slave data in order.
REQ-038 Write burst bl=3 with wdat_valid low 5 cycles mid-burst -> wb_stb_i=0, wb_cyc_i=1 during the gap; correct data order.
REQ-039 bl=0 command -> err pulse, no wb_cyc_i; slave never acks with TO_MAX=8 -> abort after 8 cycles, err=1, done=0.
REQ-040 RESETN low during beat 2 of a bl=8 read -> all outputs 0 immediately; after release and init, a new burst completes normally.
